bcd_disp_mux: RTL

BCD_DISP_MUX -- requirements
Module: bcd_disp_mux

---
 rtl/bcd_disp_mux.sv | 107 ++++++++++
 1 files changed

// File: rtl/bcd_disp_mux.sv
`default_nettype none
// ============================================================================
// Module  : bcd_disp_mux
// Brief   : Four-digit multiplexed 7-segment driver with a once-per-frame
//           snapshot and optional leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_disp_mux #(
    parameter int N = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_in,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    logic [N-1:0] q;
    logic [3:0]   sh3, sh2, sh1, sh0, sh_dp;
    logic [1:0]   slot;
    logic         frame_end;
    logic [3:0]   digit;
    logic         dp_bit;
    logic         lz_zero;
    logic [6:0]   seg7;
    logic [3:0]   an_nxt;
    logic [7:0]   sseg_nxt;

    assign slot      = q[N-1:N-2];
    assign frame_end = &q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q + 1'b1;
        end
    end

    // Snapshot taken on the last clock of a frame so a frame never mixes values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh3   <= 4'd0;
            sh2   <= 4'd0;
            sh1   <= 4'd0;
            sh0   <= 4'd0;
            sh_dp <= 4'd0;
        end else if (frame_end) begin
            sh3   <= d3;
            sh2   <= d2;
            sh1   <= d1;
            sh0   <= d0;
            sh_dp <= dp_in;
        end
    end

    always_comb begin
        digit   = sh0;
        lz_zero = 1'b0;
        case (slot)
            2'd0: begin digit = sh0; lz_zero = 1'b0; end
            2'd1: begin digit = sh1; lz_zero = (sh3 == 4'd0) && (sh2 == 4'd0) && (sh1 == 4'd0); end
            2'd2: begin digit = sh2; lz_zero = (sh3 == 4'd0) && (sh2 == 4'd0); end
            default: begin digit = sh3; lz_zero = (sh3 == 4'd0); end
        endcase
        dp_bit = sh_dp[slot];

        case (digit)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h3F;
        endcase

        an_nxt   = 4'b1111;
        sseg_nxt = 8'hFF;
        if (en && !(blank_lz && lz_zero)) begin
            an_nxt   = ~(4'b0001 << slot);
            sseg_nxt = {~dp_bit, seg7};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an   <= 4'b1111;
            sseg <= 8'hFF;
        end else begin
            an   <= an_nxt;
            sseg <= sseg_nxt;
        end
    end

endmodule
`default_nettype wire
